// File: rtl/pll_lock_clkgen_pkg.sv
// Shared types and constants for the PLL lock qualifier and clock-enable generator.
package pll_lock_clkgen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    SEQ,
    RUN
  } state_e;

  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/pll_lock_clkgen_if.sv
// Lock input, divisor bus and channel enable/reset outputs of pll_lock_clkgen.
interface pll_lock_clkgen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
);

  logic                                       pll_locked_i;
  logic [NUM_CH*DIV_W-1:0]                    div_i;
  logic [NUM_CH-1:0]                          ce_o;
  logic [NUM_CH-1:0]                          ch_rst_n_o;
  logic                                       ready_o;
  logic [pll_lock_clkgen_pkg::LOSS_CNT_W-1:0] lock_loss_cnt_o;

  modport slave (
    input  pll_locked_i,
    input  div_i,
    output ce_o,
    output ch_rst_n_o,
    output ready_o,
    output lock_loss_cnt_o
  );

  modport master (
    output pll_locked_i,
    output div_i,
    input  ce_o,
    input  ch_rst_n_o,
    input  ready_o,
    input  lock_loss_cnt_o
  );

endinterface

// File: rtl/pll_lock_clkgen_ce_divider.sv
// One channel's clock-enable divider: strobes every eff_div cycles while its reset is released.
module ce_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] eff_div;

  // The divisor is only looked at on reload, so a running period is never cut short.
  always_comb begin
    eff_div = (div_i == '0) ? DIV_W'(1) : div_i;
    cnt_d   = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = eff_div - DIV_W'(1);
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ce_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/pll_lock_clkgen.sv
// Qualifies PLL lock, releases channel resets in a staggered order and drives
// per-channel clock-enable strobes; counts lock losses seen after sequencing starts.
module pll_lock_clkgen
  import pll_lock_clkgen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int LOCK_FILTER = 1024,
  parameter int STAGGER     = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                refclk,
  input logic                rst_n,
  pll_lock_clkgen_if.slave   bus
);

  localparam int LAST_REL = (NUM_CH - 1) * STAGGER;
  localparam int SEQ_W    = (LAST_REL > 0) ? $clog2(LAST_REL + 1) : 1;
  localparam int FILT_W   = $clog2(LOCK_FILTER + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;

  state_e                 state_q, state_d;
  logic [FILT_W-1:0]      filt_q, filt_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic [NUM_CH-1:0]      rel_q, rel_d;
  logic                   ready_q, ready_d;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
  logic [NUM_CH-1:0]      ce;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked_i};
    end
  end

  assign lk_s = sync_q[SYNC_STAGES-1];

  // A lock drop in SEQ or RUN overrides any release or reload happening in the same cycle.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    seq_d   = seq_q;
    rel_d   = rel_q;
    ready_d = 1'b0;
    loss_d  = loss_q;
    unique case (state_q)
      WAIT_LOCK: begin
        filt_d = '0;
        seq_d  = '0;
        rel_d  = '0;
        if (lk_s) begin
          state_d = FILTER;
          filt_d  = FILT_W'(1);
        end
      end
      FILTER: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
        end else if (filt_q == FILT_W'(LOCK_FILTER)) begin
          filt_d   = '0;
          seq_d    = '0;
          rel_d[0] = 1'b1;
          state_d  = (LAST_REL == 0) ? RUN : SEQ;
        end else begin
          filt_d = filt_q + FILT_W'(1);
        end
      end
      SEQ, RUN: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          seq_d   = '0;
          rel_d   = '0;
          if (loss_q != '1) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end else if (state_q == RUN) begin
          ready_d = 1'b1;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
          for (int k = 1; k < NUM_CH; k++) begin
            if (seq_d == SEQ_W'(k * STAGGER)) begin
              rel_d[k] = 1'b1;
            end
          end
          if (seq_d == SEQ_W'(LAST_REL)) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      seq_q   <= '0;
      rel_q   <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      seq_q   <= seq_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ce_divider #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk   (refclk),
      .rst_n (rst_n),
      .en_i  (rel_q[k]),
      .div_i (bus.div_i[k*DIV_W +: DIV_W]),
      .ce_o  (ce[k])
    );
  end

  assign bus.ce_o            = ce;
  assign bus.ch_rst_n_o      = rel_q;
  assign bus.ready_o         = ready_q;
  assign bus.lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_lock_clkgen.sv
// Self-checking bench for pll_lock_clkgen: expected release cycles and strobe
// cycles are queued when stimulus is applied and popped as the DUT produces them.
module tb_pll_lock_clkgen;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 16;
  localparam int LOCK_FILTER = 8;
  localparam int STAGGER     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int REL0_LAT    = SYNC_STAGES + 1 + LOCK_FILTER;

  typedef struct {
    int ch;
    int cyc;
  } rel_ev_t;

  logic    refclk = 1'b0;
  logic    rst_n  = 1'b0;
  int      cyc    = 0;
  int      checks = 0;
  int      errors = 0;
  int      rel2Cyc = 0;
  rel_ev_t relQ[$];
  int      strobeQ[$];

  pll_lock_clkgen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  pll_lock_clkgen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_FILTER (LOCK_FILTER),
    .STAGGER     (STAGGER),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setDiv(input int k, input int v);
    bus.div_i[k*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pll_locked_i = 1'b0;
    setDiv(0, 0);
    setDiv(1, 1);
    setDiv(2, 3);
    repeat (3) @(negedge refclk);
    checks++; if (bus.ce_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_ce: got %b, expected 000", bus.ce_o); end
    checks++; if (bus.ch_rst_n_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_ch_rst_n: got %b, expected 000", bus.ch_rst_n_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b, expected 0", bus.ready_o); end
    checks++; if (bus.lock_loss_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_loss_cnt: got %0d, expected 0", bus.lock_loss_cnt_o); end
    @(posedge refclk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge refclk);
    checks++; if (bus.ch_rst_n_o !== 3'b000) begin errors++; $display("[TB] FAIL wait_lock_hold: got %b, expected 000", bus.ch_rst_n_o); end
  endtask

  task automatic test_lockup(input int expLoss);
    rel_ev_t    ev;
    logic [2:0] prev;
    logic       prevRdy;
    int         t0;
    int         rdyCyc;
    @(posedge refclk); #1;
    bus.pll_locked_i = 1'b1;
    t0 = cyc;
    for (int k = 0; k < NUM_CH; k++) begin
      ev.ch  = k;
      ev.cyc = t0 + REL0_LAT + k * STAGGER;
      relQ.push_back(ev);
    end
    rel2Cyc = t0 + REL0_LAT + 2 * STAGGER;
    rdyCyc  = -1;
    @(negedge refclk);
    prev    = bus.ch_rst_n_o;
    prevRdy = bus.ready_o;
    repeat (30) begin
      @(negedge refclk);
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.ch_rst_n_o[k] && !prev[k]) begin
          checks++;
          if (relQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL lockup_release: got unexpected ch%0d release at cycle %0d, expected none", k, cyc - t0);
          end else begin
            ev = relQ.pop_front();
            if (ev.ch !== k || ev.cyc !== cyc) begin
              errors++;
              $display("[TB] FAIL lockup_release: got ch%0d at cycle %0d, expected ch%0d at cycle %0d", k, cyc - t0, ev.ch, ev.cyc - t0);
            end
          end
        end
      end
      if (bus.ready_o && !prevRdy && rdyCyc < 0) rdyCyc = cyc;
      prev    = bus.ch_rst_n_o;
      prevRdy = bus.ready_o;
    end
    checks++; if (relQ.size() != 0) begin errors++; $display("[TB] FAIL lockup_missing: got %0d releases pending, expected 0", relQ.size()); end
    relQ.delete();
    checks++; if (rdyCyc !== t0 + REL0_LAT + 2 * STAGGER + 1) begin errors++; $display("[TB] FAIL lockup_ready: got rise at cycle %0d, expected %0d", rdyCyc - t0, REL0_LAT + 2 * STAGGER + 1); end
    checks++; if (bus.ch_rst_n_o !== 3'b111) begin errors++; $display("[TB] FAIL lockup_all_released: got %b, expected 111", bus.ch_rst_n_o); end
    checks++; if (bus.lock_loss_cnt_o !== 8'(expLoss)) begin errors++; $display("[TB] FAIL lockup_loss_cnt: got %0d, expected %0d", bus.lock_loss_cnt_o, expLoss); end
  endtask

  task automatic test_divider();
    logic expCe2;
    int   now;
    now = cyc;
    for (int c = rel2Cyc; c <= now + 15; c += 3) begin
      if (c > now) strobeQ.push_back(c);
    end
    repeat (15) begin
      @(negedge refclk);
      expCe2 = (strobeQ.size() > 0 && strobeQ[0] == cyc);
      if (expCe2) void'(strobeQ.pop_front());
      checks++;
      if (bus.ce_o !== {expCe2, 2'b11}) begin
        errors++;
        $display("[TB] FAIL divider_ce: got %b at cycle %0d, expected %b", bus.ce_o, cyc, {expCe2, 2'b11});
      end
    end
    strobeQ.delete();
  endtask

  task automatic test_div_change();
    logic expCe2;
    bit   found;
    int   s;
    found = 1'b0;
    repeat (10) begin
      @(negedge refclk);
      if (bus.ce_o[2]) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL divchg_find_strobe: got no ch2 strobe in 10 cycles, expected one");
      return;
    end
    s = cyc;
    @(posedge refclk); #1;
    setDiv(2, 5);
    strobeQ.push_back(s + 3);
    strobeQ.push_back(s + 8);
    strobeQ.push_back(s + 13);
    strobeQ.push_back(s + 18);
    repeat (18) begin
      @(negedge refclk);
      expCe2 = (strobeQ.size() > 0 && strobeQ[0] == cyc);
      if (expCe2) void'(strobeQ.pop_front());
      checks++;
      if (bus.ce_o[2] !== expCe2) begin
        errors++;
        $display("[TB] FAIL divchg_ce2: got %b at offset %0d, expected %b", bus.ce_o[2], cyc - s, expCe2);
      end
    end
    strobeQ.delete();
    @(posedge refclk); #1;
    setDiv(2, 3);
  endtask

  task automatic test_lock_loss();
    @(posedge refclk); #1;
    bus.pll_locked_i = 1'b0;
    repeat (3) @(negedge refclk);
    checks++; if (bus.ch_rst_n_o !== 3'b111 || bus.ready_o !== 1'b1) begin errors++; $display("[TB] FAIL loss_early: got rst_n=%b ready=%b at cycle 2, expected 111/1", bus.ch_rst_n_o, bus.ready_o); end
    @(negedge refclk);
    checks++; if (bus.ch_rst_n_o !== 3'b000) begin errors++; $display("[TB] FAIL loss_ch_rst_n: got %b, expected 000", bus.ch_rst_n_o); end
    checks++; if (bus.ce_o !== 3'b000) begin errors++; $display("[TB] FAIL loss_ce: got %b, expected 000", bus.ce_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("[TB] FAIL loss_ready: got %b, expected 0", bus.ready_o); end
    checks++; if (bus.lock_loss_cnt_o !== 8'd1) begin errors++; $display("[TB] FAIL loss_cnt: got %0d, expected 1", bus.lock_loss_cnt_o); end
  endtask

  task automatic test_loss_saturation();
    int  waited;
    for (int i = 2; i <= 300; i++) begin
      @(posedge refclk); #1;
      bus.pll_locked_i = 1'b0;
      repeat (3) @(posedge refclk);
      #1;
      bus.pll_locked_i = 1'b1;
      waited = 0;
      while (!bus.ch_rst_n_o[0] && waited < 20) begin
        @(negedge refclk);
        waited++;
      end
      if (!bus.ch_rst_n_o[0]) begin
        checks++; errors++;
        $display("[TB] FAIL sat_relock: got no ch0 release in 20 cycles at loss %0d, expected release", i);
        break;
      end
      if (i == 254) begin
        checks++; if (bus.lock_loss_cnt_o !== 8'd254) begin errors++; $display("[TB] FAIL sat_count_254: got %0d, expected 254", bus.lock_loss_cnt_o); end
      end
    end
    checks++; if (bus.lock_loss_cnt_o !== 8'd255) begin errors++; $display("[TB] FAIL sat_count_255: got %0d, expected 255", bus.lock_loss_cnt_o); end
    waited = 0;
    while (!bus.ready_o && waited < 40) begin
      @(negedge refclk);
      waited++;
    end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("[TB] FAIL sat_ready: got %b, expected 1", bus.ready_o); end
  endtask

  task automatic test_async_reset();
    @(negedge refclk);
    checks++; if (bus.ce_o[0] !== 1'b1 || bus.ready_o !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre: got ce0=%b ready=%b, expected 1/1", bus.ce_o[0], bus.ready_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ch_rst_n_o !== 3'b000) begin errors++; $display("[TB] FAIL areset_ch_rst_n: got %b, expected 000", bus.ch_rst_n_o); end
    checks++; if (bus.ce_o !== 3'b000) begin errors++; $display("[TB] FAIL areset_ce: got %b, expected 000", bus.ce_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_ready: got %b, expected 0", bus.ready_o); end
    checks++; if (bus.lock_loss_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL areset_loss_cnt: got %0d, expected 0", bus.lock_loss_cnt_o); end
  endtask

  task automatic test_filter_glitch();
    rel_ev_t    ev;
    logic [2:0] prev;
    int         t0;
    @(posedge refclk); #1;
    bus.pll_locked_i = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge refclk);
    #1;
    bus.pll_locked_i = 1'b1;
    t0 = cyc;
    // Second synchronised rise lands at t0+8, so filtering restarts from there.
    for (int k = 0; k < NUM_CH; k++) begin
      ev.ch  = k;
      ev.cyc = t0 + 8 + 1 + LOCK_FILTER + k * STAGGER;
      relQ.push_back(ev);
    end
    @(negedge refclk);
    prev = bus.ch_rst_n_o;
    repeat (36) begin
      @(negedge refclk);
      if (cyc == t0 + 5) bus.pll_locked_i = 1'b0;
      if (cyc == t0 + 6) bus.pll_locked_i = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.ch_rst_n_o[k] && !prev[k]) begin
          checks++;
          if (relQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL glitch_release: got unexpected ch%0d release at cycle %0d, expected none", k, cyc - t0);
          end else begin
            ev = relQ.pop_front();
            if (ev.ch !== k || ev.cyc !== cyc) begin
              errors++;
              $display("[TB] FAIL glitch_release: got ch%0d at cycle %0d, expected ch%0d at cycle %0d", k, cyc - t0, ev.ch, ev.cyc - t0);
            end
          end
        end
      end
      prev = bus.ch_rst_n_o;
    end
    checks++; if (relQ.size() != 0) begin errors++; $display("[TB] FAIL glitch_missing: got %0d releases pending, expected 0", relQ.size()); end
    relQ.delete();
    checks++; if (bus.lock_loss_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL glitch_loss_cnt: got %0d, expected 0", bus.lock_loss_cnt_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("[TB] FAIL glitch_ready: got %b, expected 1", bus.ready_o); end
  endtask

  initial begin
    bus.pll_locked_i = 1'b0;
    bus.div_i        = '0;
    $display("[TB] starting pll_lock_clkgen bench");
    test_reset();
    test_lockup(0);
    test_divider();
    test_div_change();
    test_lock_loss();
    test_lockup(1);
    test_loss_saturation();
    test_async_reset();
    test_filter_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
